// File: rtl/booth_skip_mult.sv
`default_nettype none
// ============================================================================
//  Module      : booth_skip_mult
//  Description : Sequential signed/unsigned multiplier using Booth recoding
//                with run skipping. Each RUN cycle jumps straight to the next
//                0<->1 transition in the extended multiplier and performs a
//                single add or subtract of the shifted multiplicand, so runs
//                of identical bits cost no cycles.
//  Ports       : clk          - clock, rising edge
//                rst          - asynchronous active-low reset
//                start        - request, sampled only in IDLE
//                signed_mode  - 1 = two's complement, 0 = unsigned
//                a, b         - multiplicand / multiplier (latched on start)
//                busy         - high while an operation is running
//                done         - one-cycle pulse when product becomes valid
//                product      - result, held until the next accepted start
//                ops          - add/sub operations for last/current operation
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_skip_mult #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [CW-1:0]        ops
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   ax_q, ax_d;
    logic [WIDTH+1:0]     bx_q, bx_d;
    logic [CW-1:0]        pos_q, pos_d;
    logic [CW-1:0]        ops_q, ops_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 done_q, done_d;

    // Transition j exists where bx[j+1] != bx[j]; only positions at or above
    // pos are still pending. Once pos reaches WIDTH+1 the whole mask is clear.
    logic [WIDTH:0]       w_trans;
    logic [WIDTH:0]       w_cand;
    logic                 w_found;
    logic                 w_sub;
    logic [CW-1:0]        w_jsel;
    logic [2*WIDTH-1:0]   w_shifted;

    assign w_trans = bx_q[WIDTH+1:1] ^ bx_q[WIDTH:0];

    for (genvar j = 0; j <= WIDTH; j++) begin : g_mask
        assign w_cand[j] = w_trans[j] && (CW'(j) >= pos_q);
    end

    // Priority search: lowest pending transition wins.
    always_comb begin
        w_found = 1'b0;
        w_sub   = 1'b0;
        w_jsel  = '0;
        for (int j = 0; j <= WIDTH; j++) begin
            if (w_cand[j] && !w_found) begin
                w_found = 1'b1;
                w_jsel  = CW'(j);
                // 0->1 going upward (bx[j+1]=1) starts a run: subtract.
                w_sub   = bx_q[j+1];
            end
        end
    end

    assign w_shifted = ax_q << w_jsel;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        ax_d      = ax_q;
        bx_d      = bx_q;
        pos_d     = pos_q;
        ops_d     = ops_q;
        product_d = product_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ops_d   = '0;
                    pos_d   = '0;
                    ax_d    = signed_mode ? {{WIDTH{a[WIDTH-1]}}, a}
                                          : {{WIDTH{1'b0}}, a};
                    bx_d    = {signed_mode & b[WIDTH-1], b, 1'b0};
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (w_found) begin
                    acc_d = w_sub ? (acc_q - w_shifted) : (acc_q + w_shifted);
                    pos_d = w_jsel + CW'(1);
                    ops_d = ops_q + CW'(1);
                end else begin
                    product_d = acc_q;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            ax_q      <= '0;
            bx_q      <= '0;
            pos_q     <= '0;
            ops_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            ax_q      <= ax_d;
            bx_q      <= bx_d;
            pos_q     <= pos_d;
            ops_q     <= ops_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q == S_RUN);
    assign done    = done_q;
    assign product = product_q;
    assign ops     = ops_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_skip_mult.sv
`default_nettype none
// ============================================================================
//  Module      : tb_booth_skip_mult
//  Description : Self-checking bench for booth_skip_mult at WIDTH=8 and 16.
//                Directed vector table, reset/back-to-back sequences and a
//                randomized regression against an arithmetic reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_skip_mult;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        start8, sm8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] prod8;
    logic [3:0]  ops8;

    logic        start16, sm16, busy16, done16;
    logic [15:0] a16, b16;
    logic [31:0] prod16;
    logic [4:0]  ops16;

    booth_skip_mult #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .a(a8), .b(b8), .busy(busy8), .done(done8),
        .product(prod8), .ops(ops8)
    );

    booth_skip_mult #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
        .a(a16), .b(b16), .busy(busy16), .done(done16),
        .product(prod16), .ops(ops16)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference product: plain integer multiply of the interpreted operands.
    function automatic logic [31:0] ref_prod(input bit w16, input bit sm,
                                             input logic [15:0] av, input logic [15:0] bv);
        longint x, y, p;
        if (w16) begin
            x = sm ? longint'($signed(av)) : longint'(av);
            y = sm ? longint'($signed(bv)) : longint'(bv);
            p = x * y;
            return p[31:0];
        end else begin
            x = sm ? longint'($signed(av[7:0])) : longint'(av[7:0]);
            y = sm ? longint'($signed(bv[7:0])) : longint'(bv[7:0]);
            p = x * y;
            return {16'h0, p[15:0]};
        end
    endfunction

    // Number of adjacent-bit changes in {ext, b, 0}.
    function automatic int ref_ops(input bit w16, input bit sm, input logic [15:0] bv);
        int          w;
        int          n;
        logic [17:0] bx;
        w  = w16 ? 16 : 8;
        bx = '0;
        for (int i = 0; i < w; i++) bx[i+1] = bv[i];
        bx[w+1] = sm & bv[w-1];
        n = 0;
        for (int i = 0; i <= w; i++) if (bx[i+1] != bx[i]) n++;
        return n;
    endfunction

    // Called right after a falling edge; returns at the falling edge where
    // done is seen, so a following call starts in the done cycle.
    task automatic run_op(input bit w16, input bit sm, input logic [15:0] av,
                          input logic [15:0] bv, input bit noise,
                          output logic [31:0] prod, output int opsn,
                          output int edges, output int busyc);
        logic [31:0] prev;
        bit          seen;
        prev = w16 ? prod16 : {16'h0, prod8};
        if (w16) begin sm16 = sm; a16 = av; b16 = bv; start16 = 1'b1; end
        else     begin sm8 = sm; a8 = av[7:0]; b8 = bv[7:0]; start8 = 1'b1; end
        @(posedge clk);
        edges = 1;
        busyc = 0;
        seen  = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 40; k++) begin
            if (w16 ? done16 : done8) begin
                seen = 1'b1;
                break;
            end
            if (w16 ? busy16 : busy8) busyc++;
            if (noise && k == 0)
                chk("product_hold_while_busy", w16 ? prod16 : {16'h0, prod8}, prev);
            if (noise && k < 3) begin
                start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = ~sm8;
            end else begin
                start8 = 1'b0; start16 = 1'b0;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        start8  = 1'b0;
        start16 = 1'b0;
        if (!seen) chk("done_timeout", 0, 1);
        prod = w16 ? prod16 : {16'h0, prod8};
        opsn = w16 ? int'(ops16) : int'(ops8);
    endtask

    typedef struct {
        bit          sm;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        int          ops;
        int          edges;
        bit          noise;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] p, ep;
        int          o, e, bc, eo;
        bit          w16, sm;
        logic [15:0] av, bv;

        tbl[0] = '{1'b0, 8'd13,  8'h00, 16'h0000, 0, 2,  1'b0};
        tbl[1] = '{1'b0, 8'd3,   8'hFF, 16'd765,  2, 4,  1'b0};
        tbl[2] = '{1'b1, 8'd3,   8'hFF, 16'hFFFD, 1, 3,  1'b0};
        tbl[3] = '{1'b1, 8'h80,  8'h80, 16'h4000, 1, 3,  1'b0};
        tbl[4] = '{1'b0, 8'hFF,  8'h55, 16'h54AB, 8, 10, 1'b1};
        tbl[5] = '{1'b1, 8'hFB,  8'h07, 16'hFFDD, 2, 4,  1'b0};
        tbl[6] = '{1'b0, 8'hFF,  8'hFF, 16'hFE01, 2, 4,  1'b0};

        rst = 1'b0;
        start8 = 0; sm8 = 0; a8 = 0; b8 = 0;
        start16 = 0; sm16 = 0; a16 = 0; b16 = 0;
        repeat (2) @(negedge clk);
        chk("reset_busy8",    busy8,  0);
        chk("reset_done8",    done8,  0);
        chk("reset_product8", prod8,  0);
        chk("reset_ops8",     ops8,   0);
        chk("reset_busy16",   busy16, 0);
        chk("reset_product16", prod16, 0);
        rst = 1'b1;
        @(negedge clk);

        // Directed table; consecutive entries start in the previous done cycle.
        for (int i = 0; i < 7; i++) begin
            run_op(1'b0, tbl[i].sm, {8'h0, tbl[i].a}, {8'h0, tbl[i].b}, tbl[i].noise, p, o, e, bc);
            chk($sformatf("vec%0d_product", i), p, {16'h0, tbl[i].p});
            chk($sformatf("vec%0d_ops", i),     o, tbl[i].ops);
            chk($sformatf("vec%0d_edges", i),   e, tbl[i].edges);
        end

        // done must be a single-cycle pulse.
        @(negedge clk);
        chk("done_pulse_width", done8, 0);

        // Reset mid-operation aborts immediately.
        a8 = 8'hFF; b8 = 8'h55; sm8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrun_reset_busy",    busy8, 0);
        chk("midrun_reset_done",    done8, 0);
        chk("midrun_reset_product", prod8, 0);
        chk("midrun_reset_ops",     ops8,  0);
        @(negedge clk);
        chk("midrun_reset_no_done", done8, 0);
        rst = 1'b1;
        @(negedge clk);
        run_op(1'b0, 1'b0, 16'd7, 16'd9, 1'b0, p, o, e, bc);
        chk("after_reset_product", p, 32'd63);
        chk("after_reset_ops",     o, 4);

        // Randomized regression, both widths and both modes.
        for (int i = 0; i < 80; i++) begin
            w16 = (i >= 40);
            sm  = 1'($urandom);
            av  = 16'($urandom);
            bv  = 16'($urandom);
            case ($urandom_range(0, 7))
                0: bv = 16'h0000;
                1: bv = 16'hFFFF;
                2: av = 16'h8000 >> (w16 ? 0 : 8);
                default: ;
            endcase
            if (!w16) begin av[15:8] = 8'h0; bv[15:8] = 8'h0; end
            ep = ref_prod(w16, sm, av, bv);
            eo = ref_ops(w16, sm, bv);
            run_op(w16, sm, av, bv, 1'b0, p, o, e, bc);
            chk($sformatf("rnd%0d_w%0d_sm%0d_product a=%0h b=%0h", i, w16 ? 16 : 8, sm, av, bv), p, ep);
            chk($sformatf("rnd%0d_ops", i),      o,  eo);
            chk($sformatf("rnd%0d_busy_len", i), bc, eo + 1);
            chk($sformatf("rnd%0d_edges", i),    e,  eo + 2);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/booth_skip_mult.md
Name: booth_skip_mult

Overview:
- Parametrised sequential signed/unsigned multiplier that combines control and datapath in one block. It uses Booth recoding with run skipping.
- Each RUN cycle jumps directly to the next 0↔1 transition in the multiplier and performs one add or subtract of the shifted multiplicand. Runs of identical bits cost no cycles.
- It is a self-contained compute unit behind a start/done handshake, for use by the lab top-level and successor datapaths.

Parameters:
- WIDTH, 8, operand width in bits; minimum 2.
- CW, $clog2(WIDTH+2), width of the ops counter (derived; not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; latched on accepted start.
- a  input  WIDTH  multiplicand; latched on accepted start.
- b  input  WIDTH  multiplier; latched on accepted start.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse when product becomes valid.
- product  output  2*WIDTH  result, held until the next accepted start.
- ops  output  CW  number of add/sub operations performed for the last or current operation.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy=0, done=0, product=0, ops=0; all internal registers cleared. Reset during RUN aborts the operation; no done is produced.
- States: IDLE, RUN. busy is 1 exactly when state is RUN. done is registered.
- IDLE, start=1 at an edge:
  - acc=0, ops=0, pos=0, state→RUN.
  - ax = a sign-extended (signed_mode=1) or zero-extended (signed_mode=0) to 2*WIDTH.
  - bx = {ext, b, 1'b0}, WIDTH+2 bits, with ext = signed_mode ? b[WIDTH-1] : 0.
  - start is also accepted in the cycle where done=1.
- IDLE, start=0: hold; product and ops stay stable.
- RUN, each edge:
  - Find the smallest j, pos ≤ j ≤ WIDTH, with bx[j+1] != bx[j]. This is a combinational priority search over a mask of bits at or above pos.
  - If found and bx[j+1]=1: acc ← acc − (ax<<j).
  - If found and bx[j+1]=0: acc ← acc + (ax<<j).
  - After either update: pos ← j+1, ops ← ops+1, stay in RUN.
  - If none is found: product ← acc, done ← 1 for one cycle, state → IDLE.
- Arithmetic is modulo 2^(2*WIDTH). The result equals a*b exactly for both modes; no overflow is possible.
- start while busy is ignored. Input changes during RUN have no effect because operands are latched.
- Latency: with T transitions in bx, the accepting edge is followed by T+1 RUN edges. done is high in the cycle after the last RUN edge.
- T bounds:
  - T ≤ WIDTH+1 unsigned; T ≤ WIDTH signed.
  - b=0 gives T=0; b=all-ones signed gives T=1.
  - Minimum start-to-done is 2 edges.
- pos may reach WIDTH+1. The search must then return none, with no out-of-range index.
- product is updated only at the done transition. The previous product is visible while busy.

Test Plan:
- WIDTH=8, unsigned, a=13, b=0 → no ops, done 2 edges after start, product=0, ops=0.
- Unsigned, a=3, b=8'hFF → subtract at j=0, add at j=8; product=16'd765, ops=2, done 4 edges after start.
- Signed, a=3, b=8'hFF (−1) → single subtract at j=0; product=16'hFFFD, ops=1. Signed a=8'h80, b=8'h80 → product=16'h4000, ops=1.
- Unsigned, a=8'hFF, b=8'h55 → ops=8, product=16'h54AB, done 10 edges after start. During RUN, start=1 is ignored and product holds its old value until done.
- Reset asserted mid-RUN → busy, done, product and ops are 0 immediately; a new start after release completes correctly. Back-to-back start in the done cycle is accepted.
- Random regression at WIDTH=8 and WIDTH=16, both modes, against a reference multiply.
  - Check ops equals the transition count of bx.
  - Check busy duration is ops+1 cycles.
